pe_packet_tx: RTL and testbench

// - Clocked transmitter from a PE into the router's PE_in port: the sending end of the 35-bit 4-phase bundled-data link.
// - Accepts spike/weight packets from the synchronous PE over valid/ready.
// - Stamps each packet with the local node ID and queues it in a FIFO.
// - Drives req/data to the router; 2-flop-synchronised ack completes the return-to-zero handshake.

---
 rtl/pe_packet_tx.sv | 168 ++++++++++++++++
 tb/tb_pe_packet_tx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_packet_tx.sv
// pe_packet_tx: clocked sender for the 35-bit 4-phase bundled-data link into
// the router's PE_in port. Packets from the PE are stamped with SRC_ID, queued
// in a small FIFO and sent one at a time with a return-to-zero handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | link quiet; pops the FIFO head into net_data when one is queued
// S_SETUP    | net_data settling one cycle (or more, if ack_s is still high)
// S_WAIT_ACK | net_req=1, waiting for the synchronised ack to rise
// S_WAIT_RTZ | net_req=0, waiting for the synchronised ack to fall
module pe_packet_tx #(
  parameter logic [3:0] SRC_ID  = 4'd0,
  parameter int         DEPTH   = 4,
  parameter int         TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_type,
  input  logic [3:0]             in_dest,
  input  logic [23:0]            in_payload,
  output logic                   net_req,
  output logic [34:0]            net_data,
  input  logic                   net_ack,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETUP    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_WAIT_RTZ = 2'd3
  } state_t;

  state_t          state;
  logic [34:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic            ack_m;
  logic            ack_s;
  logic [TW-1:0]   tmr;
  logic            push;
  logic            pop;
  logic            tmr_hit;

  // in_ready is registered, so it already reflects the current occupancy
  assign push = in_valid && in_ready;
  assign pop  = (state == S_IDLE) && (fifo_count != '0);

  // Timer reaches its terminal count only while genuinely stuck in a wait state
  assign tmr_hit = (tmr == TW'(1)) &&
                   (((state == S_WAIT_ACK) && !ack_s) ||
                    ((state == S_WAIT_RTZ) &&  ack_s));

  assign busy = (state != S_IDLE) || (fifo_count != '0);

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel
  always_comb begin
    count_nxt = fifo_count;
    if (push && !pop) begin
      count_nxt = fifo_count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = fifo_count - CW'(1);
    end
  end

  // Packet storage, stamped with the local node ID on the way in
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_type, in_dest, SRC_ID, in_payload};
    end
  end

  // FIFO pointers, occupancy and the registered not-full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count <= count_nxt;
      in_ready   <= (count_nxt != CW'(DEPTH));
    end
  end

  // Two-flop synchroniser for the asynchronous router ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= net_ack;
      ack_s <= ack_m;
    end
  end

  // Handshake FSM with wait timer and sticky timeout flag (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      net_req     <= 1'b0;
      net_data    <= '0;
      tmr         <= TMR_LOAD;
      timeout_err <= 1'b0;
    end else begin
      if (tmr_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            net_data <= mem[rd_ptr];
            state    <= S_SETUP;
            tmr      <= TMR_LOAD;
          end
        end
        S_SETUP: begin
          if (!ack_s) begin
            net_req <= 1'b1;
            state   <= S_WAIT_ACK;
            tmr     <= TMR_LOAD;
          end
        end
        S_WAIT_ACK: begin
          if (ack_s) begin
            net_req <= 1'b0;
            state   <= S_WAIT_RTZ;
            tmr     <= TMR_LOAD;
          end else if (tmr != '0) begin
            tmr <= tmr - TW'(1);
          end
        end
        S_WAIT_RTZ: begin
          if (!ack_s) begin
            state <= S_IDLE;
            tmr   <= TMR_LOAD;
          end else if (tmr != '0) begin
            tmr <= tmr - TW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          net_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_packet_tx.sv
// Bench for pe_packet_tx: a packet-queue model checked every cycle on the
// falling edge, a simple 4-phase router responder, and directed scenarios.
module tb_pe_packet_tx;

  localparam logic [3:0] SRC     = 4'd5;
  localparam int         DEPTH   = 4;
  localparam int         TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_type = '0;
  logic [3:0]  in_dest = '0;
  logic [23:0] in_payload = '0;
  logic        net_req;
  logic [34:0] net_data;
  logic        net_ack = 1'b0;
  logic [2:0]  fifo_count;
  logic        busy;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int nchk = 0;
  int nerr = 0;

  pe_packet_tx #(.SRC_ID(SRC), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_dest(in_dest), .in_payload(in_payload),
    .net_req(net_req), .net_data(net_data), .net_ack(net_ack),
    .fifo_count(fifo_count), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", nchk, nerr);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [34:0] pkt(input logic [2:0] t, input logic [3:0] d, input logic [23:0] p);
    return {t, d, SRC, p};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_true(input string name, input bit ok, input logic [63:0] act, input logic [63:0] ref_val);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h, reference %0h (t=%0t)", name, act, ref_val, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [34:0] exp_q[$];
  int          pushed = 0;
  int          started = 0;
  int          delivered = 0;
  bit          pend = 1'b0;
  logic [34:0] pend_word = '0;
  logic        prev_req = 1'b0;
  logic [34:0] prev_data = '0;
  int          rel = 0;
  int          quiet = 0;
  int          max_cnt = 0;
  bit          chk_err = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_net_req", 64'(net_req), 64'(1'b0));
      check("rst_net_data", 64'(net_data), 64'(35'd0));
      check("rst_fifo_count", 64'(fifo_count), 64'(3'd0));
      check("rst_busy", 64'(busy), 64'(1'b0));
      check("rst_in_ready", 64'(in_ready), 64'(1'b0));
      check("rst_timeout_err", 64'(timeout_err), 64'(1'b0));
      exp_q.delete();
      pushed    = 0;
      started   = 0;
      pend      = 1'b0;
      prev_req  = 1'b0;
      prev_data = '0;
      rel       = 0;
      quiet     = 0;
    end else begin
      int d;
      bit ok;
      if (pend) begin
        exp_q.push_back(pend_word);
        pushed++;
      end
      if (rel == 0) check("in_ready_first_cycle", 64'(in_ready), 64'(1'b0));
      else          check("in_ready_vs_full", 64'(in_ready), 64'(fifo_count != 3'(DEPTH)));
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (net_req || prev_req) check("net_data_stable", 64'(net_data), 64'(prev_data));
      if (net_req && !prev_req) begin
        started++;
        expect_true("deliver_avail", exp_q.size() != 0, 64'(net_data), 64'(exp_q.size()));
        if (exp_q.size() != 0) begin
          check("deliver_data", 64'(net_data), 64'(exp_q[0]));
          void'(exp_q.pop_front());
          delivered++;
        end
      end
      d = pushed - started;
      if (net_req) begin
        check("count_in_flight", 64'(fifo_count), 64'(d));
      end else begin
        ok = (int'(fifo_count) == d) || (d >= 1 && int'(fifo_count) == d - 1);
        expect_true("count_idle", ok, 64'(fifo_count), 64'(d));
      end
      if (fifo_count != 3'd0 || net_req) check("busy_active", 64'(busy), 64'(1'b1));
      if (net_req || net_ack) quiet = 0;
      else                    quiet++;
      if (quiet >= 5 && pushed == started) check("busy_idle", 64'(busy), 64'(1'b0));
      if (chk_err) check("timeout_err_low", 64'(timeout_err), 64'(1'b0));
      prev_req  = net_req;
      prev_data = net_data;
      pend      = in_valid && in_ready;
      pend_word = pkt(in_type, in_dest, in_payload);
      rel++;
    end
  end

  // ---------------- router-side ack responder ----------------
  int   resp_mode = 0;   // 0: follow man_ack, 1: fixed delay, 2: random delay
  logic man_ack = 1'b0;
  int   fixed_dly = 0;
  int   rdly = 0;
  int   rcnt = 0;

  always @(posedge clk) begin
    int cur;
    #2;
    cur = (resp_mode == 2) ? rdly : fixed_dly;
    if (!rst_n) begin
      net_ack = 1'b0;
      rcnt    = 0;
    end else if (resp_mode == 0) begin
      net_ack = man_ack;
    end else if (!net_ack) begin
      if (net_req) begin
        if (rcnt >= cur) begin
          net_ack = 1'b1;
          rcnt    = 0;
        end else begin
          rcnt++;
        end
      end
    end else if (!net_req) begin
      net_ack = 1'b0;
      rdly    = int'($urandom_range(0, 20));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] t, input logic [3:0] d, input logic [23:0] p);
    int n = 0;
    in_type    = t;
    in_dest    = d;
    in_payload = p;
    in_valid   = 1'b1;
    while (!in_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!in_ready) check("push_accept_timeout", 64'(in_ready), 64'(1'b1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input logic v, input string name);
    int n = 0;
    while (net_req !== v && n < 3000) begin
      tick();
      n++;
    end
    if (net_req !== v) check(name, 64'(net_req), 64'(v));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!(pushed == started && exp_q.size() == 0 && !net_req && !net_ack && !busy && !in_valid)
           && n < 5000) begin
      tick();
      n++;
    end
    expect_true(name, (pushed == started) && !busy && !net_req, 64'(fifo_count), 64'(pushed - started));
  endtask

  // ---------------- directed and random scenarios ----------------
  initial begin
    logic [23:0] pb;
    int          base;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // T1: single packet, literal word and edge-exact latency
    resp_mode = 0;
    man_ack   = 1'b0;
    tick();
    tick();
    in_type = 3'd1; in_dest = 4'd3; in_payload = 24'hABCDEF; in_valid = 1'b1;
    tick();                                   // edge 0: handshake
    in_valid = 1'b0;
    check("t1_req_edge0", 64'(net_req), 64'(1'b0));
    tick();                                   // edge 1
    check("t1_data_literal", 64'(net_data), 64'(35'h135ABCDEF));
    check("t1_req_edge1", 64'(net_req), 64'(1'b0));
    tick();                                   // edge 2
    check("t1_req_edge2", 64'(net_req), 64'(1'b1));
    man_ack = 1'b1;                           // ack rises before edge 3
    tick();
    tick();
    check("t1_req_ack_plus2", 64'(net_req), 64'(1'b1));
    tick();
    check("t1_req_ack_plus3", 64'(net_req), 64'(1'b0));
    man_ack = 1'b0;
    drain("t1_drain");

    // T2: six back-to-back packets, responder delays 5 cycles
    resp_mode = 1;
    fixed_dly = 5;
    max_cnt   = 0;
    for (int i = 0; i < 6; i++) push(3'($urandom), 4'($urandom), 24'($urandom));
    drain("t2_drain");
    check("t2_full_reached", 64'(max_cnt), 64'(DEPTH));

    // T3: push lands on the same edge as a pop at count 2
    resp_mode = 0;
    man_ack   = 1'b0;
    tick();
    push(3'd2, 4'd1, 24'h000A0A);
    pb = 24'h000B0B;
    push(3'd2, 4'd2, pb);
    push(3'd2, 4'd3, 24'h000C0C);
    wait_req(1'b1, "t3_req_rise");
    check("t3_count_before", 64'(fifo_count), 64'(3'd2));
    man_ack = 1'b1;
    wait_req(1'b0, "t3_req_fall");
    man_ack = 1'b0;                           // ack falls before Q1
    tick();
    tick();
    tick();                                   // Q3: FSM back in IDLE
    check("t3_count_at_idle", 64'(fifo_count), 64'(3'd2));
    in_type = 3'd2; in_dest = 4'd4; in_payload = 24'h000D0D; in_valid = 1'b1;
    tick();                                   // Q4: pop and push together
    in_valid = 1'b0;
    check("t3_count_same", 64'(fifo_count), 64'(3'd2));
    check("t3_popped_b", 64'(net_data), 64'(pkt(3'd2, 4'd2, pb)));
    resp_mode = 1;
    fixed_dly = 0;
    drain("t3_drain");

    // T4: withheld ack -> timeout, late ack, sticky flag, clear
    chk_err   = 1'b0;
    resp_mode = 0;
    man_ack   = 1'b0;
    push(3'd7, 4'd9, 24'h123456);
    wait_req(1'b1, "t4_req_rise");
    repeat (TIMEOUT - 4) tick();
    check("t4_err_not_yet", 64'(timeout_err), 64'(1'b0));
    repeat (8) tick();
    check("t4_err_set", 64'(timeout_err), 64'(1'b1));
    check("t4_req_held", 64'(net_req), 64'(1'b1));
    man_ack = 1'b1;
    wait_req(1'b0, "t4_late_ack");
    man_ack = 1'b0;
    drain("t4_drain");
    check("t4_err_sticky", 64'(timeout_err), 64'(1'b1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err_cleared", 64'(timeout_err), 64'(1'b0));
    chk_err = 1'b1;

    // T5: reset in WAIT_ACK with three queued
    resp_mode = 0;
    man_ack   = 1'b0;
    for (int i = 0; i < 4; i++) push(3'($urandom), 4'($urandom), 24'($urandom));
    wait_req(1'b1, "t5_req_rise");
    tick();
    check("t5_count_queued", 64'(fifo_count), 64'(3'd3));
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_req", 64'(net_req), 64'(1'b0));
    check("t5_async_count", 64'(fifo_count), 64'(3'd0));
    tick();
    tick();
    tick();
    rst_n     = 1'b1;
    resp_mode = 1;
    fixed_dly = 2;
    push(3'd4, 4'd6, 24'h5A5A5A);
    drain("t5_drain");

    // T6: 200 random packets, random ack delays 0..20
    resp_mode = 2;
    base      = delivered;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      push(3'($urandom), 4'($urandom), 24'($urandom));
    end
    drain("t6_drain");
    check("t6_delivered", 64'(delivered - base), 64'(200));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
